// File: rtl/idu_pipe_stage.sv
// Registered RV64I/RV32I decode stage: decodes, reads/forwards operands, tracks busy destinations.
// Latency 1 cycle; in_ready drops on a RAW/WAW hazard, on a held result with out_ready low, or on flush.
module idu_pipe_stage #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    input  logic [XLEN-1:0] rs1_data,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_valid,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_alu_ctl,
    output logic [3:0]      out_funct,
    output logic            out_rd_ena,
    output logic [4:0]      out_rd_addr,
    output logic            out_jump
);
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    logic            valid_q;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] wb_clear;
    logic [NREG-1:0] busy_eff;

    logic [4:0]      rs1, rs2, rd;
    logic            is_opimm, is_auipc, is_jal, is_lui, is_op, is_jalr, is_ill;
    logic            rs1_used, rs2_used, rd_ena;
    logic [63:0]     imm64;
    logic [XLEN-1:0] imm, rs1_val, rs2_val, op1, op2;
    logic            hz, accept, out_fire;

    function automatic logic conflict(input logic [4:0] a, input logic [NREG-1:0] bvec,
                                      input logic held, input logic [4:0] held_rd);
        logic hit;
        hit = held && (held_rd == a);
        for (int i = 1; i < NREG; i++) begin
            if (bvec[i] && (a == 5'(i))) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            wb_clear[i] = wb_valid && (wb_addr == 5'(i));
        end
    end

    assign busy_eff = busy & ~wb_clear;

    always_comb begin
        rs1      = in_inst[19:15];
        rs2      = in_inst[24:20];
        rd       = in_inst[11:7];
        is_opimm = (in_inst[6:0] == OPC_OPIMM);
        is_auipc = (in_inst[6:0] == OPC_AUIPC);
        is_jal   = (in_inst[6:0] == OPC_JAL);
        is_lui   = (in_inst[6:0] == OPC_LUI);
        is_op    = (in_inst[6:0] == OPC_OP);
        is_jalr  = (in_inst[6:0] == OPC_JALR);
        is_ill   = !(is_opimm || is_auipc || is_jal || is_lui || is_op || is_jalr);
        rs1_used = is_opimm || is_op || is_jalr;
        rs2_used = is_op;
        rd_ena   = !is_ill && (rd != 5'd0);

        imm64 = 64'd0;
        if (is_opimm || is_jalr) imm64 = {{52{in_inst[31]}}, in_inst[31:20]};
        else if (is_lui || is_auipc) imm64 = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
        else if (is_jal) imm64 = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                  in_inst[20], in_inst[30:21], 1'b0};
        imm = imm64[XLEN-1:0];

        // x0 reads as zero; same-cycle writeback overrides the regfile read
        rs1_val = '0;
        if (rs1 != 5'd0) rs1_val = (wb_valid && wb_addr == rs1) ? wb_data : rs1_data;
        rs2_val = '0;
        if (rs2 != 5'd0) rs2_val = (wb_valid && wb_addr == rs2) ? wb_data : rs2_data;

        op1 = '0;
        if (rs1_used) op1 = rs1_val;
        else if (is_auipc || is_jal) op1 = in_pc;
        op2 = '0;
        if (rs2_used) op2 = rs2_val;
        else if (is_opimm || is_lui || is_auipc || is_jalr || is_jal) op2 = imm;

        rs1_addr = rs1_used ? rs1 : 5'd0;
        rs2_addr = rs2_used ? rs2 : 5'd0;

        hz = (rs1_used && rs1 != 5'd0 && conflict(rs1, busy_eff, valid_q && out_rd_ena, out_rd_addr))
          || (rs2_used && rs2 != 5'd0 && conflict(rs2, busy_eff, valid_q && out_rd_ena, out_rd_addr))
          || (rd_ena && conflict(rd, busy_eff, valid_q && out_rd_ena, out_rd_addr));
    end

    assign in_ready  = (!valid_q || out_ready) && !hz && !flush;
    assign out_valid = valid_q && !flush;
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            busy        <= '0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_pc      <= '0;
            out_alu_ctl <= '0;
            out_funct   <= '0;
            out_rd_ena  <= 1'b0;
            out_rd_addr <= '0;
            out_jump    <= 1'b0;
        end else begin
            if (flush) valid_q <= 1'b0;
            else if (accept) valid_q <= 1'b1;
            else if (out_fire) valid_q <= 1'b0;

            if (accept) begin
                out_op1     <= op1;
                out_op2     <= op2;
                out_pc      <= in_pc;
                out_alu_ctl <= {is_ill, is_jalr, is_op, is_lui, is_jal, is_auipc, is_opimm};
                out_funct   <= {in_inst[30], in_inst[14:12]};
                out_rd_ena  <= rd_ena;
                out_rd_addr <= rd_ena ? rd : 5'd0;
                out_jump    <= is_jal || is_jalr;
            end

            // a set on handoff takes priority over a same-cycle writeback clear
            busy[0] <= 1'b0;
            for (int i = 1; i < NREG; i++) begin
                if (out_fire && out_rd_ena && out_rd_addr == 5'(i)) busy[i] <= 1'b1;
                else if (wb_clear[i]) busy[i] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_idu_pipe_stage.sv
// Directed bench for idu_pipe_stage with an expected-result queue checked at each output handoff.
module tb_idu_pipe_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, wb_valid, flush, out_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc, rs1_data, rs2_data, wb_data, out_op1, out_op2, out_pc;
    logic [4:0]  rs1_addr, rs2_addr, wb_addr, out_rd_addr;
    logic [6:0]  out_alu_ctl;
    logic [3:0]  out_funct;
    logic        out_rd_ena, out_jump;
    logic [63:0] regs [32];

    typedef struct {
        logic [63:0] op1, op2, pc;
        logic [6:0]  alu;
        logic [3:0]  funct;
        logic        rd_ena;
        logic [4:0]  rd;
        logic        jump;
    } exp_t;

    exp_t cur;
    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    idu_pipe_stage #(.XLEN(64), .NREG(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs2_addr(rs2_addr),
        .rs2_data(rs2_data), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1),
        .out_op2(out_op2), .out_pc(out_pc), .out_alu_ctl(out_alu_ctl), .out_funct(out_funct),
        .out_rd_ena(out_rd_ena), .out_rd_addr(out_rd_addr), .out_jump(out_jump)
    );

    always #5 clk = ~clk;

    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] op1, input logic [63:0] op2, input logic [63:0] pc,
                                input logic [6:0] alu, input logic [3:0] funct, input logic rd_ena,
                                input logic [4:0] rd, input logic jump);
        exp_t e;
        e.op1 = op1; e.op2 = op2; e.pc = pc; e.alu = alu; e.funct = funct;
        e.rd_ena = rd_ena; e.rd = rd; e.jump = jump;
        return e;
    endfunction

    task automatic pop_check();
        exp_t e;
        if (q.size() == 0) begin
            chk("unexpected_output", 64'd1, 64'd0);
            return;
        end
        e = q.pop_front();
        chk("op1", out_op1, e.op1);
        chk("op2", out_op2, e.op2);
        chk("pc", out_pc, e.pc);
        chk("alu_ctl", 64'(out_alu_ctl), 64'(e.alu));
        chk("funct", 64'(out_funct), 64'(e.funct));
        chk("rd_ena", 64'(out_rd_ena), 64'(e.rd_ena));
        chk("rd_addr", 64'(out_rd_addr), 64'(e.rd));
        chk("jump", 64'(out_jump), 64'(e.jump));
    endtask

    // One clock: observe handshakes just before the edge, then step to 1ns after it.
    task automatic tick();
        #2;
        if (out_valid && out_ready) pop_check();
        if (in_valid && in_ready) q.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [31:0] inst, input logic [63:0] pc, input exp_t e);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        cur      = e;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_inst  = 32'd0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [63:0] d);
        wb_valid = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 64'd0;
        regs[1] = 64'h11;
        regs[2] = 64'd7;
        rst = 1'b1; in_valid = 1'b0; in_inst = 32'd0; in_pc = 64'd0;
        wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 64'd0; flush = 1'b0; out_ready = 1'b1;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_op1", out_op1, 64'd0);
        chk("rst_alu", 64'(out_alu_ctl), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // auipc, jal, lui, illegal back to back
        drv(32'h00001197, 64'h80000000, mk(64'h80000000, 64'h1000, 64'h80000000, 7'b0000010, 4'b0001, 1, 3, 0));
        tick();
        drv(32'h008000EF, 64'h80000004, mk(64'h80000004, 64'd8, 64'h80000004, 7'b0000100, 4'b0000, 1, 1, 1));
        tick();
        drv(32'h800002B7, 64'h80000008, mk(64'd0, 64'hFFFFFFFF80000000, 64'h80000008, 7'b0001000, 4'b0000, 1, 5, 0));
        tick();
        drv(32'h0000007F, 64'h40, mk(64'd0, 64'd0, 64'h40, 7'b1000000, 4'b0000, 0, 0, 0));
        #1;
        chk("ill_rs1_addr", 64'(rs1_addr), 64'd0);
        chk("ill_rs2_addr", 64'(rs2_addr), 64'd0);
        chk("ill_in_ready", 64'(in_ready), 64'd1);
        tick();
        idle();
        tick();
        wb(5'd1, 64'd0); wb(5'd3, 64'd0); wb(5'd5, 64'd0);

        // addi x1,x2,5 then dependent add stalls until writeback forwards 0x55
        drv(32'h00510093, 64'h100, mk(64'd7, 64'd5, 64'h100, 7'b0000001, 4'b0000, 1, 1, 0));
        tick();
        idle();
        tick();
        drv(32'h002081B3, 64'h104, mk(64'h55, 64'd7, 64'h104, 7'b0010000, 4'b0000, 1, 3, 0));
        #1;
        chk("raw_rs1_addr", 64'(rs1_addr), 64'd1);
        chk("raw_rs2_addr", 64'(rs2_addr), 64'd2);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("raw_stall", 64'(in_ready), 64'd0);
            tick();
        end
        wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 64'h55;
        #1;
        chk("raw_release", 64'(in_ready), 64'd1);
        tick();
        wb_valid = 1'b0;
        idle();
        tick();
        wb(5'd3, 64'd0);

        // backpressure: hold for 3 cycles, then stream with no bubble
        out_ready = 1'b0;
        drv(32'h00100313, 64'h300, mk(64'd0, 64'd1, 64'h300, 7'b0000001, 4'b0000, 1, 6, 0));
        tick();
        drv(32'h00200393, 64'h304, mk(64'd0, 64'd2, 64'h304, 7'b0000001, 4'b0000, 1, 7, 0));
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_op2_hold", out_op2, 64'd1);
            chk("bp_rd_hold", 64'(out_rd_addr), 64'd6);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_ready", 64'(in_ready), 64'd1);
        tick();
        drv(32'h00300413, 64'h308, mk(64'd0, 64'd3, 64'h308, 7'b0000001, 4'b0000, 1, 8, 0));
        #1;
        chk("bp_no_bubble_vld", 64'(out_valid), 64'd1);
        chk("bp_no_bubble_rdy", 64'(in_ready), 64'd1);
        tick();
        idle();
        tick();
        wb(5'd6, 64'd0); wb(5'd7, 64'd0);

        // flush drops the held instruction; x8 stays busy across it
        drv(32'h00400493, 64'h200, mk(64'd0, 64'd4, 64'h200, 7'b0000001, 4'b0000, 1, 9, 0));
        tick();
        drv(32'h00500513, 64'h204, mk(64'd0, 64'd5, 64'h204, 7'b0000001, 4'b0000, 1, 10, 0));
        flush = 1'b1;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        #1;
        chk("post_flush_valid", 64'(out_valid), 64'd0);
        chk("post_flush_ready", 64'(in_ready), 64'd1);
        tick();
        idle();
        tick();
        drv(32'h00048593, 64'h208, mk(64'd0, 64'd0, 64'h208, 7'b0000001, 4'b0000, 1, 11, 0));
        #1;
        chk("flushed_rd_not_busy", 64'(in_ready), 64'd1);
        tick();
        drv(32'h00040613, 64'h20C, mk(64'd0, 64'd0, 64'h20C, 7'b0000001, 4'b0000, 1, 12, 0));
        #1;
        chk("busy_kept_over_flush", 64'(in_ready), 64'd0);
        tick();
        idle();
        wb(5'd8, 64'd0);

        // rd=x0 yields no destination
        drv(32'h00000013, 64'h400, mk(64'd0, 64'd0, 64'h400, 7'b0000001, 4'b0000, 0, 0, 0));
        tick();
        idle();
        tick();

        // reset while holding a result
        out_ready = 1'b0;
        drv(32'h00100713, 64'h500, mk(64'd0, 64'd1, 64'h500, 7'b0000001, 4'b0000, 1, 14, 0));
        tick();
        idle();
        #1;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_op2", out_op2, 64'd0);
        chk("mid_rst_pc", out_pc, 64'd0);
        chk("mid_rst_rd", 64'(out_rd_addr), 64'd0);
        chk("mid_rst_alu", 64'(out_alu_ctl), 64'd0);

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/idu_pipe_stage.md
Name: idu_pipe_stage

Overview:
- Parametrised, registered successor to the combinational decode stage; sits between IFU and EXU.
- Decodes the RV64I/RV32I base subset: OP-IMM, OP, LUI, AUIPC, JAL, JALR.
- Reads the regfile, forwards same-cycle writeback data, and tracks in-flight destinations with a busy scoreboard for RAW/WAW stalls.
- Holds one decoded instruction in an output register behind valid/ready handshakes on both sides, and supports flush on redirect.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64. Widths of pc, op1, op2, imm and all register data.
- NREG, 32, number of architectural registers; register addresses are 5 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  IFU has an instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction pc
- rs1_addr  out  5  regfile read address 1; 0 when rs1 is unused
- rs1_data  in  XLEN  regfile read data 1, combinational
- rs2_addr  out  5  regfile read address 2; 0 when rs2 is unused
- rs2_data  in  XLEN  regfile read data 2, combinational
- wb_valid  in  1  writeback this cycle
- wb_addr  in  5  writeback register
- wb_data  in  XLEN  writeback value
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  decoded instruction available
- out_ready  in  1  EXU accepts
- out_op1  out  XLEN  operand 1
- out_op2  out  XLEN  operand 2
- out_pc  out  XLEN  pc of held instruction
- out_alu_ctl  out  7  one-hot class: bit0 OPIMM, bit1 AUIPC, bit2 JAL, bit3 LUI, bit4 OP, bit5 JALR, bit6 ILLEGAL
- out_funct  out  4  {inst[30], funct3}
- out_rd_ena  out  1  writes rd; 0 if rd==0
- out_rd_addr  out  5  destination; 0 when out_rd_ena==0
- out_jump  out  1  JAL or JALR

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
  - On reset: valid_q=0, busy[NREG-1:0]=0, and all out_* registers are 0.
  - Reset mid-handshake discards the held instruction.
- Decode: combinational from in_inst.
  - rs1 is used by OPIMM, OP and JALR.
  - rs2 is used by OP only.
  - Any other opcode sets ILLEGAL with rd_ena=0, rs1/rs2 unused, op1=op2=0.
- Immediates, all sign-extended to XLEN:
  - I-type: inst[31:20].
  - U-type: {inst[31:12],12'b0}.
  - J-type: {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
- Operand rules:
  - op1 = rs1 value if rs1 is used; in_pc for AUIPC/JAL; else 0.
  - op2 = rs2 value if rs2 is used; imm for OPIMM/LUI/AUIPC/JALR/JAL; else 0.
- Forwarding: if wb_valid and wb_addr==rsN and rsN!=0, use wb_data instead of rsN_data.
  - x0 always reads as 0.
- Hazard: hz is high when a used, nonzero rs1, rs2 or rd (rd only when rd_ena) matches either of:
  - (busy & ~wb_clear), where wb_clear is the one-hot of wb_addr when wb_valid;
  - out_rd_addr while valid_q and out_rd_ena are both high.
- Ready: in_ready = (!valid_q | out_ready) & !hz & !flush.
- Accept: on in_valid & in_ready, the output registers load the decoded fields and valid_q<=1.
  - Result appears the next cycle (1-cycle latency).
- Output valid: out_valid = valid_q & !flush.
- Drain: on out_valid & out_ready with no new accept, valid_q<=0. Back-to-back accept and drain sustains 1 instr/cycle.
- Scoreboard:
  - On out handshake with out_rd_ena, busy[out_rd_addr]<=1.
  - On wb_valid, busy[wb_addr]<=0.
  - If set and clear hit the same register in the same cycle, set wins.
  - busy[0] is never set.
- Flush:
  - valid_q<=0 at the edge.
  - The held instruction is dropped and never sets busy.
  - No accept occurs in the flush cycle.
  - Existing busy bits are kept; already-issued instructions still write back.
- Stability: output registers hold while valid_q & !out_ready.
- Width: with XLEN=32, all immediate and pc arithmetic truncates to 32 bits.

Test Plan:
- addi x1,x2,5 (0x00510093), x2=7, out_ready=1 -> next cycle out_valid=1, op1=7, op2=5, alu_ctl=0000001, rd_addr=1; after handoff busy[1]=1.
- auipc x3,1 (0x00001197) at pc 0x80000000 -> op1=0x80000000, op2=0x1000, alu_ctl=0000010; jal x1,8 (0x008000EF) -> op2=8, out_jump=1.
- RAW stall: addi x1 issued and busy, then add x3,x1,x2 (0x002081B3) -> in_ready=0 until wb_valid with wb_addr=1, wb_data=0x55. In that cycle the instruction is accepted with op1=0x55 via forwarding.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable; when out_ready=1, one handoff per cycle with no bubble.
- Flush: with valid_q=1, assert flush for one cycle alongside in_valid -> out_valid=0 that cycle, no accept, busy unchanged; next instruction is accepted the following cycle.
- Edge cases:
  - lui x5,0x80000 with XLEN=64 -> op2=0xFFFFFFFF80000000.
  - Unknown opcode 0x0000007F -> alu_ctl=1000000, rd_ena=0.
  - rd=x0 never sets busy.
  - rst asserted while out_valid=1 -> all outputs 0 next cycle.
